// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and limits for the IF/MEM memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IF   = 2'd1,
    ARB_DM   = 2'd2
  } arb_state_t;

  localparam int CNT_W       = 4;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = (1 << CNT_W) - 1;

  function automatic bit mem_lat_legal(input int lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_lat_timer.sv
// rtl/mem_lat_timer.sv - loadable down-counter that parks at zero and flags it
module mem_lat_timer
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency memory port between fetch and data access
// ARB_PERF_CNT_EN adds saturating stall-cycle counters perf_if_stall / perf_dm_stall.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              flush_if,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [3:0]        dm_be,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_fetch,
  output logic              stall_mem
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_stall,
  output logic [31:0]       perf_dm_stall
`endif
);

  if (!mem_lat_legal(MEM_LAT)) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT out of range");
  end

  localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(MEM_LAT);

  arb_state_t        state_q, state_d;
  logic              kill_q, kill_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_zero, resp, arb_open, grant_dm, grant_if;

  mem_lat_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (grant_dm | grant_if),
    .load_val (LAT_LD),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    resp     = (state_q != ARB_IDLE) && cnt_zero;
    dm_done  = (state_q == ARB_DM) && resp;
    if_valid = (state_q == ARB_IF) && resp && !kill_q;
    dm_rdata = dm_done  ? mem_rdata : '0;
    if_rdata = if_valid ? mem_rdata : '0;
    stall_fetch = if_req & ~if_valid;
    stall_mem   = dm_req & ~dm_done;

    // A killed fetch did not complete, so its requester stays eligible on that edge.
    arb_open = (state_q == ARB_IDLE) || resp;
    grant_dm = arb_open && dm_req && !dm_done;
    grant_if = arb_open && !grant_dm && if_req && !flush_if && !if_valid;

    state_d = state_q;
    if (grant_dm) begin
      state_d = ARB_DM;
    end else if (grant_if) begin
      state_d = ARB_IF;
    end else if (resp) begin
      state_d = ARB_IDLE;
    end

    kill_d = kill_q;
    if (resp) begin
      kill_d = 1'b0;
    end else if ((state_q == ARB_IF) && flush_if) begin
      kill_d = 1'b1;
    end

    mem_en_d    = grant_dm | grant_if;
    mem_we_d    = grant_dm & dm_we;
    mem_addr_d  = grant_dm ? dm_addr : (grant_if ? if_addr : '0);
    mem_wdata_d = grant_dm ? dm_wdata : '0;
    mem_be_d    = grant_dm ? dm_be : (grant_if ? 4'hF : 4'h0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      kill_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_q, perf_if_d, perf_dm_q, perf_dm_d;

  always_comb begin
    perf_if_d = perf_if_q;
    perf_dm_d = perf_dm_q;
    if (stall_fetch && (perf_if_q != '1)) perf_if_d = perf_if_q + 32'd1;
    if (stall_mem && (perf_dm_q != '1)) perf_dm_d = perf_dm_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_q <= '0;
      perf_dm_q <= '0;
    end else begin
      perf_if_q <= perf_if_d;
      perf_dm_q <= perf_dm_d;
    end
  end

  assign perf_if_stall = perf_if_q;
  assign perf_dm_stall = perf_dm_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with a behavioural memory
module tb_mem_port_arbiter;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, flush_if, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_valid, dm_done, mem_en, mem_we, stall_fetch, stall_mem;
  logic [3:0]  mem_be;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_stall, perf_dm_stall;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] mem_arr [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] rd_slot [16];
  logic        rd_vld  [16];

  logic        hist_en [64];
  logic        hist_we [64];
  logic [31:0] hist_addr [64];
  logic [31:0] hist_wdata [64];
  logic [3:0]  hist_be [64];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .flush_if(flush_if),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata),
    .stall_fetch(stall_fetch), .stall_mem(stall_mem)
`ifdef ARB_PERF_CNT_EN
    , .perf_if_stall(perf_if_stall), .perf_dm_stall(perf_dm_stall)
`endif
  );

  function automatic logic [31:0] init_word(input int i);
    return (i * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Fixed-latency memory: data for a mem_en in cycle c is presented throughout cycle c+MEM_LAT.
  initial begin
    for (int i = 0; i < 1024; i++) mem_arr[i] = init_word(i);
    for (int i = 0; i < 16; i++) begin rd_slot[i] = '0; rd_vld[i] = 1'b0; end
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      #2;
      for (int i = 0; i < 15; i++) begin rd_slot[i] = rd_slot[i+1]; rd_vld[i] = rd_vld[i+1]; end
      rd_vld[15] = 1'b0;
      if (mem_en === 1'b1) begin
        rd_slot[MEM_LAT-1] = mem_arr[mem_addr[11:2]];
        rd_vld[MEM_LAT-1]  = 1'b1;
        if (mem_we === 1'b1) mem_arr[mem_addr[11:2]] = merge_be(mem_arr[mem_addr[11:2]], mem_wdata, mem_be);
      end
      mem_rdata = rd_vld[0] ? rd_slot[0] : $urandom;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; flush_if = 0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    idle_inputs();
    repeat (2) next_cycle();
    rst_n = 1;
    next_cycle();
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    #3;
    total_cnt++; if ({mem_en, mem_we, if_valid, dm_done, stall_fetch, stall_mem} !== 6'b0) $display("FAIL reset_flags got=%b exp=000000", {mem_en, mem_we, if_valid, dm_done, stall_fetch, stall_mem}); else pass_cnt++;
    total_cnt++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); else pass_cnt++;
    total_cnt++; if (mem_wdata !== 32'h0 || mem_be !== 4'h0) $display("FAIL reset_wdata_be got=%h/%h exp=0/0", mem_wdata, mem_be); else pass_cnt++;
    total_cnt++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) $display("FAIL reset_rdata got=%h/%h exp=0/0", if_rdata, dm_rdata); else pass_cnt++;
`ifdef ARB_PERF_CNT_EN
    total_cnt++; if (perf_if_stall !== 32'h0 || perf_dm_stall !== 32'h0) $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_if_stall, perf_dm_stall); else pass_cnt++;
`endif
    apply_reset();
  endtask

  task automatic test_lone_fetch();
    for (int k = 0; k < 5; k++) begin
      if_req = (k <= 3); if_addr = 32'h100;
      @(negedge clk);
      total_cnt++; if (mem_en !== (k == 1)) $display("FAIL lone_mem_en k=%0d got=%b exp=%b", k, mem_en, k == 1); else pass_cnt++;
      if (k == 1) begin
        total_cnt++; if (mem_addr !== 32'h100 || mem_we !== 1'b0) $display("FAIL lone_mem_addr got=%h/%b exp=100/0", mem_addr, mem_we); else pass_cnt++;
      end
      total_cnt++; if (if_valid !== (k == 3)) $display("FAIL lone_if_valid k=%0d got=%b exp=%b", k, if_valid, k == 3); else pass_cnt++;
      total_cnt++; if (if_rdata !== ((k == 3) ? ref_mem[64] : 32'h0)) $display("FAIL lone_if_rdata k=%0d got=%h exp=%h", k, if_rdata, (k == 3) ? ref_mem[64] : 32'h0); else pass_cnt++;
      total_cnt++; if (stall_fetch !== (k <= 2)) $display("FAIL lone_stall k=%0d got=%b exp=%b", k, stall_fetch, k <= 2); else pass_cnt++;
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_collision();
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      dm_req = (k <= 3); dm_we = 0; dm_addr = 32'h2000;
      if_req = (k <= 6); if_addr = 32'h300;
      @(negedge clk);
      total_cnt++; if (mem_en !== (k == 1 || k == 4)) $display("FAIL coll_mem_en k=%0d got=%b exp=%b", k, mem_en, k == 1 || k == 4); else pass_cnt++;
      if (k == 1) begin
        total_cnt++; if (mem_addr !== 32'h2000 || mem_we !== 1'b0) $display("FAIL coll_dm_addr got=%h/%b exp=2000/0", mem_addr, mem_we); else pass_cnt++;
      end
      if (k == 4) begin
        total_cnt++; if (mem_addr !== 32'h300 || mem_we !== 1'b0) $display("FAIL coll_if_addr got=%h/%b exp=300/0", mem_addr, mem_we); else pass_cnt++;
      end
      total_cnt++; if (dm_done !== (k == 3)) $display("FAIL coll_dm_done k=%0d got=%b exp=%b", k, dm_done, k == 3); else pass_cnt++;
      total_cnt++; if (dm_rdata !== ((k == 3) ? ref_mem[0] : 32'h0)) $display("FAIL coll_dm_rdata k=%0d got=%h exp=%h", k, dm_rdata, (k == 3) ? ref_mem[0] : 32'h0); else pass_cnt++;
      total_cnt++; if (if_valid !== (k == 6)) $display("FAIL coll_if_valid k=%0d got=%b exp=%b", k, if_valid, k == 6); else pass_cnt++;
      total_cnt++; if (if_rdata !== ((k == 6) ? ref_mem[192] : 32'h0)) $display("FAIL coll_if_rdata k=%0d got=%h exp=%h", k, if_rdata, (k == 6) ? ref_mem[192] : 32'h0); else pass_cnt++;
      total_cnt++; if ({stall_mem, stall_fetch} !== {k <= 2, k <= 5}) $display("FAIL coll_stall k=%0d got=%b%b exp=%b%b", k, stall_mem, stall_fetch, k <= 2, k <= 5); else pass_cnt++;
      next_cycle();
    end
    idle_inputs();
`ifdef ARB_PERF_CNT_EN
    total_cnt++; if (perf_dm_stall !== 32'd3) $display("FAIL coll_perf_dm got=%0d exp=3", perf_dm_stall); else pass_cnt++;
    total_cnt++; if (perf_if_stall !== 32'd6) $display("FAIL coll_perf_if got=%0d exp=6", perf_if_stall); else pass_cnt++;
`endif
  endtask

  task automatic test_store();
    logic [31:0] wd [3];
    logic [3:0]  be [3];
    wd[0] = 32'hDEADBEEF; be[0] = 4'hF;
    wd[1] = 32'h11223344; be[1] = 4'b0101;
    wd[2] = 32'h0;        be[2] = 4'h0;
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 5; k++) begin
        dm_req = (k <= 3); dm_we = (t < 2); dm_addr = 32'h40; dm_wdata = wd[t]; dm_be = be[t];
        @(negedge clk);
        total_cnt++; if (mem_en !== (k == 1)) $display("FAIL store_mem_en t=%0d k=%0d got=%b exp=%b", t, k, mem_en, k == 1); else pass_cnt++;
        if (k == 1 && t < 2) begin
          total_cnt++; if ({mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h40, wd[t], be[t]}) $display("FAIL store_fields t=%0d got=%b/%h/%h/%h exp=1/40/%h/%h", t, mem_we, mem_addr, mem_wdata, mem_be, wd[t], be[t]); else pass_cnt++;
        end
        total_cnt++; if (dm_done !== (k == 3)) $display("FAIL store_done t=%0d k=%0d got=%b exp=%b", t, k, dm_done, k == 3); else pass_cnt++;
        if (k == 3 && t == 2) begin
          total_cnt++; if (dm_rdata !== ref_mem[16]) $display("FAIL store_readback got=%h exp=%h", dm_rdata, ref_mem[16]); else pass_cnt++;
        end
        if (k == 3 && t < 2) ref_mem[16] = merge_be(ref_mem[16], wd[t], be[t]);
        next_cycle();
      end
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    for (int k = 0; k < 8; k++) begin
      if_req = (k <= 6); if_addr = (k <= 2) ? 32'h100 : 32'h200; flush_if = (k == 2);
      @(negedge clk);
      total_cnt++; if (mem_en !== (k == 1 || k == 4)) $display("FAIL flush_mem_en k=%0d got=%b exp=%b", k, mem_en, k == 1 || k == 4); else pass_cnt++;
      if (k == 4) begin
        total_cnt++; if (mem_addr !== 32'h200) $display("FAIL flush_new_addr got=%h exp=200", mem_addr); else pass_cnt++;
      end
      total_cnt++; if (if_valid !== (k == 6)) $display("FAIL flush_if_valid k=%0d got=%b exp=%b", k, if_valid, k == 6); else pass_cnt++;
      total_cnt++; if (if_rdata !== ((k == 6) ? ref_mem[128] : 32'h0)) $display("FAIL flush_if_rdata k=%0d got=%h exp=%h", k, if_rdata, (k == 6) ? ref_mem[128] : 32'h0); else pass_cnt++;
      total_cnt++; if (stall_fetch !== (k <= 5)) $display("FAIL flush_stall k=%0d got=%b exp=%b", k, stall_fetch, k <= 5); else pass_cnt++;
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 9; k++) begin
      dm_we = 0; dm_addr = 32'h80;
      dm_req = (k <= 1) || (k >= 4 && k <= 7);
      rst_n = !(k == 2 || k == 3);
      @(negedge clk);
      total_cnt++; if (mem_en !== (k == 1 || k == 5)) $display("FAIL rstmid_mem_en k=%0d got=%b exp=%b", k, mem_en, k == 1 || k == 5); else pass_cnt++;
      total_cnt++; if (dm_done !== (k == 7)) $display("FAIL rstmid_dm_done k=%0d got=%b exp=%b", k, dm_done, k == 7); else pass_cnt++;
      total_cnt++; if (dm_rdata !== ((k == 7) ? ref_mem[32] : 32'h0)) $display("FAIL rstmid_dm_rdata k=%0d got=%h exp=%h", k, dm_rdata, (k == 7) ? ref_mem[32] : 32'h0); else pass_cnt++;
      if (k == 2 || k == 3) begin
        total_cnt++; if ({mem_addr, if_valid, stall_mem} !== 34'h0) $display("FAIL rstmid_outputs k=%0d got=%h/%b/%b exp=0/0/0", k, mem_addr, if_valid, stall_mem); else pass_cnt++;
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_random();
    bit if_out = 0, dm_out = 0;
    int if_t0 = 0, dm_t0 = 0, h, a;
    apply_reset();
    for (int i = 0; i < 64; i++) hist_en[i] = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!if_out) if_req = 0;
      if (!dm_out) dm_req = 0;
      flush_if = 0;
      if (if_out && $urandom_range(0, 9) == 0) flush_if = 1;
      else if (!if_out && n < 560 && $urandom_range(0, 2) == 0) begin
        a = $urandom_range(0, 1023); if_addr = a << 2; if_req = 1; if_out = 1; if_t0 = n;
      end
      if (!dm_out && n < 560 && $urandom_range(0, 2) == 0) begin
        a = $urandom_range(0, 1023); dm_addr = a << 2; dm_we = $urandom_range(0, 1);
        dm_wdata = $urandom; dm_be = 4'($urandom_range(1, 15)); dm_req = 1; dm_out = 1; dm_t0 = n;
      end
      @(negedge clk);
      hist_en[n % 64] = mem_en; hist_we[n % 64] = mem_we; hist_addr[n % 64] = mem_addr;
      hist_wdata[n % 64] = mem_wdata; hist_be[n % 64] = mem_be;
      h = (n + 64 - MEM_LAT) % 64;
      total_cnt++; if (stall_fetch !== (if_req & ~if_valid) || stall_mem !== (dm_req & ~dm_done)) $display("FAIL rnd_stall n=%0d got=%b%b exp=%b%b", n, stall_fetch, stall_mem, if_req & ~if_valid, dm_req & ~dm_done); else pass_cnt++;
      total_cnt++; if ((if_valid & dm_done) !== 1'b0) $display("FAIL rnd_both_done n=%0d got=1 exp=0", n); else pass_cnt++;
      if (if_valid === 1'b1) begin
        total_cnt++; if (!if_out) $display("FAIL rnd_spurious_if_valid n=%0d got=1 exp=0", n); else pass_cnt++;
        total_cnt++; if (if_rdata !== ref_mem[if_addr[11:2]]) $display("FAIL rnd_if_rdata n=%0d got=%h exp=%h", n, if_rdata, ref_mem[if_addr[11:2]]); else pass_cnt++;
        total_cnt++; if ({hist_en[h], hist_we[h], hist_addr[h]} !== {2'b10, if_addr}) $display("FAIL rnd_if_access n=%0d got=%b%b/%h exp=10/%h", n, hist_en[h], hist_we[h], hist_addr[h], if_addr); else pass_cnt++;
        if_out = 0;
      end else begin
        total_cnt++; if (if_rdata !== 32'h0) $display("FAIL rnd_if_rdata_idle n=%0d got=%h exp=0", n, if_rdata); else pass_cnt++;
        if (flush_if) if_out = 0;
      end
      if (dm_done === 1'b1) begin
        total_cnt++; if (!dm_out) $display("FAIL rnd_spurious_dm_done n=%0d got=1 exp=0", n); else pass_cnt++;
        total_cnt++; if ({hist_en[h], hist_we[h], hist_addr[h]} !== {1'b1, dm_we, dm_addr}) $display("FAIL rnd_dm_access n=%0d got=%b%b/%h exp=1%b/%h", n, hist_en[h], hist_we[h], hist_addr[h], dm_we, dm_addr); else pass_cnt++;
        if (dm_we) begin
          total_cnt++; if ({hist_wdata[h], hist_be[h]} !== {dm_wdata, dm_be}) $display("FAIL rnd_store_data n=%0d got=%h/%h exp=%h/%h", n, hist_wdata[h], hist_be[h], dm_wdata, dm_be); else pass_cnt++;
          ref_mem[dm_addr[11:2]] = merge_be(ref_mem[dm_addr[11:2]], dm_wdata, dm_be);
        end else begin
          total_cnt++; if (dm_rdata !== ref_mem[dm_addr[11:2]]) $display("FAIL rnd_dm_rdata n=%0d got=%h exp=%h", n, dm_rdata, ref_mem[dm_addr[11:2]]); else pass_cnt++;
        end
        dm_out = 0;
      end else begin
        total_cnt++; if (dm_rdata !== 32'h0) $display("FAIL rnd_dm_rdata_idle n=%0d got=%h exp=0", n, dm_rdata); else pass_cnt++;
      end
      if (if_out && (n - if_t0) > 4 * (MEM_LAT + 1)) begin
        total_cnt++; $display("FAIL rnd_if_timeout n=%0d waited=%0d limit=%0d", n, n - if_t0, 4 * (MEM_LAT + 1)); if_out = 0;
      end
      if (dm_out && (n - dm_t0) > 2 * (MEM_LAT + 1) + 1) begin
        total_cnt++; $display("FAIL rnd_dm_timeout n=%0d waited=%0d limit=%0d", n, n - dm_t0, 2 * (MEM_LAT + 1) + 1); dm_out = 0;
      end
      next_cycle();
    end
    total_cnt++; if ({if_out, dm_out} !== 2'b00) $display("FAIL rnd_drain got=%b%b exp=00", if_out, dm_out); else pass_cnt++;
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_collision();
    test_lone_fetch();
    test_store();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer that shares one single-port instruction/data memory between the fetch stage (IF) and the memory stage (MEM) of the 5-stage RISC-V pipeline. It grants one access at a time, times the fixed-latency memory response, and returns the data to the owner. While a requester waits, it raises stall requests that the hazard logic ORs into stallF/stallD and the MEM-stage hold. A branch redirect (PCSrcE) kills an in-flight fetch response.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_valid or flush_if
- if_addr  in  ADDR_W  fetch PC
- if_rdata  out  DATA_W  instruction
- if_valid  out  1  one-cycle pulse: if_rdata valid
- flush_if  in  1  redirect (PCSrcE); kills fetch
- dm_req  in  1  load/store request; held until dm_done
- dm_we  in  1  1 = store
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_be  in  4  byte enables
- dm_rdata  out  DATA_W  load data
- dm_done  out  1  one-cycle pulse: access complete
- mem_en, mem_we  out  1  memory strobe / write
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_be  out  4
- mem_rdata  in  DATA_W  memory read data
- stall_fetch  out  1  = if_req & ~if_valid
- stall_mem  out  1  = dm_req & ~dm_done

## Operation
- States: ARB_IDLE, ARB_IF, ARB_DM; 4-bit down-counter cnt; kill flag.
- Arbitration at each edge in ARB_IDLE: dm_req wins over if_req (the older instruction has priority). A fetch is not granted on an edge where flush_if=1.
- Grant: state goes to owner; mem_en=1 for exactly the next cycle, with mem_addr/mem_we/mem_wdata/mem_be registered from the owner (mem_we=0 for fetch); cnt loads MEM_LAT.
- cnt decrements each cycle after the mem_en cycle. The response cycle is the cycle in which cnt reaches 0, i.e. the cycle with mem_en plus MEM_LAT.
- Response cycle:
  - dm_done=1 and dm_rdata=mem_rdata (combinational pass-through), or
  - if_valid=1 and if_rdata=mem_rdata, unless kill is set.
- Stores also complete only in the response cycle, so latency is uniform.
- Completion edge: the completing requester is excluded from arbitration on that edge. If the other requester is pending, it is granted directly with no bubble; otherwise the state returns to ARB_IDLE.
- flush_if during ARB_IF sets kill. The memory access still runs to completion, but if_valid stays 0. kill clears on the completion edge.
- flush_if has no effect on ARB_DM.
- rdata outputs are 0 outside their valid pulse.

## Timing
- Reset values: state ARB_IDLE, cnt 0, kill 0, all outputs 0. Reset mid-access abandons the access; a stale mem_rdata is ignored.
- Request-to-completion latency: MEM_LAT+1 cycles after the grant edge.
- Simultaneous requests: data completes first. Fetch mem_en is asserted in the cycle after dm_done.
- stall_* are combinational from the req inputs and state; no registered lag.
- Requester dropping req before completion is illegal.

## Configuration
- ARB_PERF_CNT_EN defined:
  - adds outputs perf_if_stall (32) and perf_dm_stall (32);
  - each counts the cycles in which stall_fetch or stall_mem is high, saturating at 0xFFFFFFFF;
  - both are cleared by rst_n.
- ARB_PERF_CNT_EN undefined: these ports and their counters are absent. All other behaviour is identical.

## Structure
- Package mem_arb_pkg holds:
  - arb_state_t enum {ARB_IDLE, ARB_IF, ARB_DM};
  - localparam CNT_W=4;
  - MEM_LAT legality check constant.
- One sub-module, mem_lat_timer: loadable down-counter with a zero flag, instantiated once.

## Test plan
All scenarios use MEM_LAT=2.
- Lone fetch: if_req=1, if_addr=0x100 at edge 0 → mem_en=1 in cycle 1 with mem_addr=0x100, mem_we=0 → if_valid=1 in cycle 3 with if_rdata=mem_rdata; stall_fetch=1 in cycles 0–2.
- Collision: if_req and dm_req (load 0x2000) both raised at edge 0 → load mem_en in cycle 1, dm_done in cycle 3 → fetch mem_en in cycle 4, if_valid in cycle 6.
- Store: dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF, dm_be=0xF → one mem_en cycle with those values and mem_we=1 → dm_done 2 cycles later.
- Flush mid-fetch: flush_if=1 in cycle 2 of the fetch → no if_valid. A new if_req (0x200) is granted on the completion edge, and its if_valid arrives 3 cycles later.
- Reset mid-access: rst_n=0 in cycle 2 of a load → all outputs 0 immediately. After release, dm_done does not appear until a new full access completes.
- With ARB_PERF_CNT_EN: the collision scenario → perf_dm_stall=3, perf_if_stall=6.
